// File: rtl/mem_access_ctrl_pkg.sv
// Shared memory-op encodings, exception codes and defaults for the memory-stage access controller.
package mem_access_ctrl_pkg;

   typedef enum logic [3:0] {
      MEMOP_NONE = 4'd0,
      MEMOP_LW   = 4'd1,
      MEMOP_LH   = 4'd2,
      MEMOP_LHU  = 4'd3,
      MEMOP_LB   = 4'd4,
      MEMOP_LBU  = 4'd5,
      MEMOP_SW   = 4'd6,
      MEMOP_SH   = 4'd7,
      MEMOP_SB   = 4'd8
   } memop_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam int unsigned DM_ADDR_WIDTH_DEF = 14;
   localparam logic [31:0] DM_BASE_DEF       = 32'h0;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   function automatic logic is_load(input memop_t op);
      return (op == MEMOP_LW) || (op == MEMOP_LH) || (op == MEMOP_LHU) ||
             (op == MEMOP_LB) || (op == MEMOP_LBU);
   endfunction

   function automatic logic is_store(input memop_t op);
      return (op == MEMOP_SW) || (op == MEMOP_SH) || (op == MEMOP_SB);
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Load data extraction: selects the byte/half addressed by the byte offset and sign/zero-extends it.
module mem_load_ext
   import mem_access_ctrl_pkg::*;
(
   input  memop_t      op,
   input  logic [1:0]  offset,
   input  logic [31:0] word,
   output logic [31:0] data
);

   logic [15:0] half;
   logic [7:0]  lane;

   always_comb begin
      half = offset[1] ? word[31:16] : word[15:0];
      lane = word[8*offset +: 8];
      case (op)
         MEMOP_LH:  data = {{16{half[15]}}, half};
         MEMOP_LHU: data = {16'h0, half};
         MEMOP_LB:  data = {{24{lane[7]}}, lane};
         MEMOP_LBU: data = {24'h0, lane};
         default:   data = word;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues one DM access per load/store, stalls until DM ready,
// returns extended load data and flags misaligned or out-of-range addresses.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned DM_ADDR_WIDTH = DM_ADDR_WIDTH_DEF,
   parameter logic [31:0] DM_BASE       = DM_BASE_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        exc,
   output logic [4:0]  exc_code,
   output logic        dm_ce,
   output logic        dm_we,
   output logic        dm_re,
   output logic [3:0]  dm_be,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_din,
   output logic [31:0] dm_pc,
   input  logic [31:0] dm_dout,
   input  logic        dm_ready
);

   state_t      state;
   memop_t      op_in, op_q;
   logic [31:0] addr_q, pc_q, din_q, rdata_q, din_in, ext_data;
   logic [3:0]  be_in, be_q;
   logic        ld_in, st_in, misaligned, out_of_range, bad, start;

   assign op_in = memop_t'(req_op);

   always_comb begin
      ld_in        = is_load(op_in);
      st_in        = is_store(op_in);
      misaligned   = 1'b0;
      case (op_in)
         MEMOP_LW, MEMOP_SW:            misaligned = (req_addr[1:0] != 2'b00);
         MEMOP_LH, MEMOP_LHU, MEMOP_SH: misaligned = req_addr[0];
         default:                       misaligned = 1'b0;
      endcase
      out_of_range = (req_addr >> DM_ADDR_WIDTH) != (DM_BASE >> DM_ADDR_WIDTH);
      bad          = req_valid & (ld_in | st_in) & (misaligned | out_of_range);
      start        = req_valid & (ld_in | st_in) & ~bad & ~flush;
   end

   // Store lanes are computed from the raw request so the DM sees them from the first ACCESS cycle.
   always_comb begin
      be_in  = 4'b1111;
      din_in = req_wdata;
      case (op_in)
         MEMOP_SH: begin
            be_in  = req_addr[1] ? 4'b1100 : 4'b0011;
            din_in = {2{req_wdata[15:0]}};
         end
         MEMOP_SB: begin
            be_in  = 4'b0001 << req_addr[1:0];
            din_in = {4{req_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   mem_load_ext u_load_ext (
      .op     (op_q),
      .offset (addr_q[1:0]),
      .word   (dm_dout),
      .data   (ext_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         op_q    <= MEMOP_NONE;
         addr_q  <= '0;
         pc_q    <= '0;
         din_q   <= '0;
         be_q    <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q   <= op_in;
                  addr_q <= req_addr;
                  pc_q   <= req_pc;
                  din_q  <= din_in;
                  be_q   <= be_in;
                  state  <= ST_ACCESS;
               end
            end
            ST_ACCESS: begin
               if (flush) begin
                  state <= ST_IDLE;
               end else if (dm_ready) begin
                  rdata_q <= ext_data;
                  state   <= ST_RESP;
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Reset is synchronous, so ce is also gated by reset to keep a mid-access reset from committing a write.
   assign dm_ce       = (state == ST_ACCESS) & ~flush & ~reset;
   assign dm_re       = (state == ST_ACCESS) & is_load(op_q);
   assign dm_we       = (state == ST_ACCESS) & is_store(op_q);
   assign dm_be       = be_q;
   assign dm_din      = din_q;
   assign dm_addr     = addr_q;
   assign dm_pc       = pc_q;
   assign rdata       = rdata_q;
   assign rdata_valid = (state == ST_RESP) & is_load(op_q) & ~flush;
   assign stall       = req_valid & ((state == ST_IDLE) ? start : (state == ST_ACCESS));
   assign exc         = (state == ST_IDLE) & bad;
   assign exc_code    = exc ? (ld_in ? EXC_ADEL : EXC_ADES) : 5'd0;

endmodule
